// File: rtl/periph_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : periph_bus_pkg
//  Description : Shared constants and types for the peripheral bus arbiter:
//                FSM state encoding and master index constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package periph_bus_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Master index constants
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_RESP   = ST_RESP
    } state_t;

endpackage : periph_bus_pkg
`default_nettype wire

// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : periph_bus_arbiter_if
//  Description : Bundle of the two master request/response channels and the
//                shared peripheral slave bus.
//                  slave  modport : arbiter view (takes requests, drives bus)
//                  master modport : requesters + peripheral view
//  Ports       : m0_*/m1_*  request, grant, done, read data per master
//                s_*        shared slave bus (s_rdata combinational from slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface periph_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_wen;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_done;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_wen;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_done;
    logic [DW-1:0] m1_rdata;

    logic          s_en;
    logic          s_wen;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_wen, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output s_en, s_wen, s_addr, s_wdata,
        input  s_rdata
    );

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_wen, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  s_en, s_wen, s_addr, s_wdata,
        output s_rdata
    );

endinterface : periph_bus_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way winner select. Combinational winner from the request
//                vector; a last-grant pointer (reset to MST_DMA so the CPU
//                wins the first contention) is updated whenever i_load is set.
//                Build option PERIPH_ARB_FIXED_PRIO_EN: M0 always wins
//                contention and no pointer exists.
//  Ports       : clk, reset  clock and synchronous active-high reset
//                i_req[1:0]  requests (bit 0 = M0, bit 1 = M1)
//                i_load      a request is being registered this edge
//                o_grant     winning master index
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import periph_bus_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] i_req,
    input  wire logic       i_load,
    output logic            o_grant
);

`ifdef PERIPH_ARB_FIXED_PRIO_EN
    // M1 only wins when it is the sole requester
    assign o_grant = (i_req == 2'b10) ? MST_DMA : MST_CPU;

    wire logic w_unused = &{1'b0, clk, reset, i_load};
`else
    logic r_last;
    logic w_grant;

    always_comb begin
        w_grant = MST_CPU;
        case (i_req)
            2'b01:   w_grant = MST_CPU;
            2'b10:   w_grant = MST_DMA;
            2'b11:   w_grant = ~r_last;   // the master not granted last time
            default: w_grant = MST_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= MST_DMA;
        end else if (i_load) begin
            r_last <= w_grant;
        end
    end

    assign o_grant = w_grant;
`endif

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : periph_bus_arbiter
//  Description : Shares one peripheral slave bus between M0 (CPU) and M1
//                (loader/DMA). A request is registered in IDLE or RESP, driven
//                on the slave bus for one ACCESS cycle, and answered with a
//                one-cycle done pulse in RESP. Round-robin on contention.
//                Build option PERIPH_ARB_FIXED_PRIO_EN (in rr_arbiter2):
//                fixed priority, M0 always wins.
//  Ports       : clk, reset  clock and synchronous active-high reset
//                bus         periph_bus_arbiter_if.slave (masters + slave bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    periph_bus_arbiter_if.slave    bus
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_load;
    logic          w_any_req;
    logic [1:0]    w_req;
    logic          w_win;
    logic          w_access;
    logic          w_resp;

    logic          r_idx;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    assign w_req     = {bus.m1_req, bus.m0_req};
    assign w_any_req = |w_req;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (w_req),
        .i_load  (w_load),
        .o_grant (w_win)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM next state ----------------
    // RESP arbitrates exactly like IDLE, giving back-to-back transfers.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_any_req) begin
                    w_state_nxt = S_ACCESS;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);

    // ---------------- Request and read-data registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= MST_CPU;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_load) begin
                r_idx   <= w_win;
                r_wen   <= (w_win == MST_DMA) ? bus.m1_wen   : bus.m0_wen;
                r_addr  <= (w_win == MST_DMA) ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= (w_win == MST_DMA) ? bus.m1_wdata : bus.m0_wdata;
            end
            // Writes leave the winner's rdata untouched
            if (w_access && !r_wen) begin
                if (r_idx == MST_DMA) begin
                    r_rdata1 <= bus.s_rdata;
                end else begin
                    r_rdata0 <= bus.s_rdata;
                end
            end
        end
    end

    // ---------------- Outputs ----------------
    assign bus.s_en     = w_access;
    assign bus.s_wen    = w_access & r_wen;
    assign bus.s_addr   = r_addr;
    assign bus.s_wdata  = r_wdata;

    assign bus.m0_gnt   = w_access & (r_idx == MST_CPU);
    assign bus.m1_gnt   = w_access & (r_idx == MST_DMA);
    assign bus.m0_done  = w_resp   & (r_idx == MST_CPU);
    assign bus.m1_done  = w_resp   & (r_idx == MST_DMA);
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_rdata = r_rdata1;

endmodule : periph_bus_arbiter
`default_nettype wire

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares one peripheral slave bus (timer, LED/digit ports) between two masters: M0 = CPU memory stage, M1 = loader/DMA engine.
- Accepts one request at a time and drives it onto the slave bus for exactly one ACCESS cycle. Slave interface: en, wen, address, din in; dout out, combinational.
- Returns read data or write completion with a one-cycle done pulse.
- Round-robin arbitration on contention.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  M0 request; held with m0_wen/m0_addr/m0_wdata stable until m0_gnt
- m0_wen  in  1  M0 write enable
- m0_addr  in  AW  M0 address
- m0_wdata  in  DW  M0 write data
- m0_gnt  out  1  M0 request accepted; pulse, ACCESS cycle
- m0_done  out  1  M0 transaction complete; pulse, RESP cycle
- m0_rdata  out  DW  M0 read data, valid with m0_done
- m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as M0, for M1
- s_en  out  1  slave enable
- s_wen  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_rdata  in  DW  slave read data, combinational from s_en/s_addr

Behaviour:
- Reset is synchronous on clk, active-high.
  - State goes to IDLE; last-grant pointer = 1, so M0 wins the first contention.
  - All outputs are 0, including s_addr, s_wdata and both rdata ports.
  - Reset during ACCESS or RESP aborts the transaction: no done is issued and the slave sees no further en.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any req at the clock edge: register the winner's wen/addr/wdata and index, then go to ACCESS.
- ACCESS, exactly 1 cycle:
  - s_en=1; s_wen/s_addr/s_wdata come from the registers.
  - Winner's gnt=1 combinationally from state and the registered index.
  - At the edge: capture s_rdata into the winner's rdata register (reads only) and go to RESP.
- RESP, 1 cycle:
  - Winner's done=1. Its rdata holds the read value; on a write, rdata holds its previous value.
  - s_en=0.
  - Arbitration is evaluated exactly as in IDLE. Any req goes to ACCESS (back-to-back); otherwise go to IDLE.
- Latency: req seen at edge E -> gnt in cycle E+1 -> done in cycle E+2. Peak throughput is 1 transaction per 2 cycles.
- Arbitration:
  - Single requester wins.
  - Both requesting: winner = master not equal to the last-grant pointer.
  - The pointer updates to the winner when a request is registered.
- No preemption: requests arriving during ACCESS are ignored until the RESP edge.
- A master dropping req before its gnt withdraws the request, but only if it has not yet been registered. Once registered, the transaction completes regardless.
- rdata registers are per master and hold their value until that master's next read completes.
- gnt and done are never both high on the same master in the same cycle. At most one gnt and at most one done are high per cycle.
- s_wen=0 whenever s_en=0.

Optional Feature:
- Macro: PERIPH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, M0 always wins contention; the pointer is not implemented.
- Undefined (default): round-robin as above.

Decomposition:
- Package periph_bus_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - master index constants: MST_CPU=1'b0, MST_DMA=1'b1
- Sub-module rr_arbiter2: combinational 2-way winner select from req[1:0] and the pointer, plus the registered pointer.
  - It contains the PERIPH_ARB_FIXED_PRIO_EN switch.
- Top level holds the FSM, request registers and rdata registers.

Test Plan:
- Read M0: reset 2 cycles, then m0_req=1, wen=0, addr=0x40000004, with s_rdata model = 0x0000_1234.
  -> s_en=1 and s_addr=0x40000004 one cycle after req; m0_gnt in the same cycle; next cycle m0_done=1, m0_rdata=0x00001234.
- Write M1: m1_req, wen=1, addr=0x40000008, wdata=0x3.
  -> exactly one cycle with s_en=1, s_wen=1, s_wdata=0x3; m1_done one cycle later; m1_rdata unchanged.
- Contention after reset: both req held continuously.
  -> grants alternate M0, M1, M0, M1; back-to-back ACCESS every 2 cycles with no IDLE gap.
  -> With PERIPH_ARB_FIXED_PRIO_EN: M0 granted every time while it requests.
- Withdraw: m1_req pulses for 0 cycles at an edge (high only between edges) while idle.
  -> no ACCESS; s_en stays 0.
- Reset mid-op: assert reset during ACCESS.
  -> next cycle all outputs 0, no done; after release, a new M0 read completes normally and M0 wins the first contention.
- Late request during ACCESS: m0 busy, m1_req rises during the ACCESS cycle.
  -> M1 registered at the RESP edge; m1_gnt two cycles after m0_gnt.
